control_sequencer: RTL and testbench

//  Hardwired control unit for the mini CPU. Fetches and decodes the IR, then steps the
//  T0..T7 micro-sequence, driving the strobes that data_path consumes
//  (PCout/Zlowout/MDRout/..., Rin/Rout selects, alu_op). It replaces the stimulus FSM

---
 rtl/cpu_ctrl_pkg.sv | 83 ++++++++
 rtl/control_sequencer_if.sv | 26 ++
 rtl/reg_select_encode.sv | 31 +++
 rtl/control_sequencer.sv | 159 +++++++++++++++
 tb/tb_control_sequencer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the mini-CPU hardwired control unit: opcodes, ALU codes,
// sequencer states and instruction-class decode helpers.
package cpu_ctrl_pkg;

    localparam int OPW  = 5;
    localparam int NREG = 16;
    localparam int CW   = 19;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3, ALU_OR = 4'd4,
        ALU_SHR  = 4'd5, ALU_SHL = 4'd6, ALU_ROR = 4'd7, ALU_ROL = 4'd8
    } alu_op_t;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic c_out;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic pc_in;
        logic inc_pc;
        logic read;
        logic write;
        logic run;
    } strobes_t;

    // Undefined opcodes fall into C_NOP so they simply refetch.
    function automatic op_class_t classify(logic [OPW-1:0] op);
        case (op)
            OP_LD:   return C_LD;
            OP_LDI:  return C_LDI;
            OP_ST:   return C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       return C_IMM;
            OP_HALT: return C_HALT;
            default: return C_NOP;
        endcase
    endfunction

    function automatic alu_op_t alu_of(logic [OPW-1:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and data_path (slave).
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [31:0]     IR;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            PCout, Zlowout, MDRout, Cout;
    logic [31:0]     C_sext;
    logic            MARin, MDRin, IRin, Yin, Zin, PCin;
    logic            IncPC, Read, Write;
    logic [3:0]      alu_op;
    logic            run;

    modport master (
        input  IR,
        output Rin, Rout, PCout, Zlowout, MDRout, Cout, C_sext,
               MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, Read, Write, alu_op, run
    );

    modport slave (
        output IR,
        input  Rin, Rout, PCout, Zlowout, MDRout, Cout, C_sext,
               MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, Read, Write, alu_op, run
    );
endinterface

// File: rtl/reg_select_encode.sv
// Turns the Ra/Rb/Rc field selected by Gra/Grb/Grc into one-hot register
// write/read selects; BAout makes R0 read as zero for base addressing.
module reg_select_encode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]      Ra,
    input  logic [3:0]      Rb,
    input  logic [3:0]      Rc,
    input  logic            Gra,
    input  logic            Grb,
    input  logic            Grc,
    input  logic            Rin_en,
    input  logic            Rout_en,
    input  logic            BAout,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout
);
    logic [3:0] sel;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel  = '0;
        Rin  = '0;
        Rout = '0;
        if (Gra)      sel = Ra;
        else if (Grb) sel = Rb;
        else if (Grc) sel = Rc;
        if (Rin_en) Rin[sel] = 1'b1;
        if (Rout_en && !(BAout && sel == 4'd0)) Rout[sel] = 1'b1;
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0..T2, execute T3..T7, HALT until clear.
// All strobes are Moore outputs of the state and IR, and are forced low while clear is low.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input logic                clock,
    input logic                clear,
    control_sequencer_if.master bus
);
    state_t          state, next_state;
    op_class_t       op_class;
    strobes_t        st;
    alu_op_t         alu_sel;
    logic            gra, grb, grc, rin_en, rout_en, ba_out;
    logic [NREG-1:0] rin_sel, rout_sel;
    logic [OPW-1:0]  op;
    logic            is_mem;

    assign op       = bus.IR[31:27];
    assign op_class = classify(op);
    assign is_mem   = (op_class == C_LD) || (op_class == C_ST);

    always_ff @(posedge clock) begin
        // NOTE: registers in always_ff use <= so every flop samples pre-edge values.
        if (!clear) state <= S_RESET;
        else        state <= next_state;
    end

    // The branch at T2 reads IR as presented for the instruction being fetched.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2: begin
                case (op_class)
                    C_NOP:   next_state = S_T0;
                    C_HALT:  next_state = S_HALT;
                    default: next_state = S_T3;
                endcase
            end
            S_T3:    next_state = S_T4;
            S_T4:    next_state = S_T5;
            S_T5:    next_state = is_mem ? S_T6 : S_T0;
            S_T6:    next_state = S_T7;
            S_T7:    next_state = S_T0;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    always_comb begin
        st      = '0;
        alu_sel = ALU_NONE;
        gra     = 1'b0;
        grb     = 1'b0;
        grc     = 1'b0;
        rin_en  = 1'b0;
        rout_en = 1'b0;
        ba_out  = 1'b0;
        st.run  = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                st.pc_out = 1'b1; st.mar_in = 1'b1; st.inc_pc = 1'b1; st.z_in = 1'b1;
                alu_sel   = ALU_ADD;
            end
            S_T1: begin
                st.zlow_out = 1'b1; st.pc_in = 1'b1; st.read = 1'b1; st.mdr_in = 1'b1;
            end
            S_T2: begin
                st.mdr_out = 1'b1; st.ir_in = 1'b1;
            end
            S_T3: begin
                grb     = 1'b1;
                rout_en = 1'b1;
                ba_out  = is_mem || (op_class == C_LDI);
                st.y_in = 1'b1;
            end
            S_T4: begin
                st.z_in = 1'b1;
                if (op_class == C_ALU) begin
                    grc     = 1'b1;
                    rout_en = 1'b1;
                    alu_sel = alu_of(op);
                end else begin
                    st.c_out = 1'b1;
                    alu_sel  = (op_class == C_IMM) ? alu_of(op) : ALU_ADD;
                end
            end
            S_T5: begin
                st.zlow_out = 1'b1;
                if (is_mem) st.mar_in = 1'b1;
                else begin
                    gra    = 1'b1;
                    rin_en = 1'b1;
                end
            end
            S_T6: begin
                st.mdr_in = 1'b1;
                if (op_class == C_LD) st.read = 1'b1;
                else begin
                    gra     = 1'b1;
                    rout_en = 1'b1;
                end
            end
            S_T7: begin
                if (op_class == C_LD) begin
                    st.mdr_out = 1'b1;
                    gra        = 1'b1;
                    rin_en     = 1'b1;
                end else begin
                    st.write = 1'b1;
                end
            end
            default: ;
        endcase
        // Asynchronous abort of the strobes: nothing reaches data_path on the reset edge.
        if (!clear) begin
            st      = '0;
            alu_sel = ALU_NONE;
            rin_en  = 1'b0;
            rout_en = 1'b0;
        end
    end

    reg_select_encode u_sel (
        .Ra      (bus.IR[26:23]),
        .Rb      (bus.IR[22:19]),
        .Rc      (bus.IR[18:15]),
        .Gra     (gra),
        .Grb     (grb),
        .Grc     (grc),
        .Rin_en  (rin_en),
        .Rout_en (rout_en),
        .BAout   (ba_out),
        .Rin     (rin_sel),
        .Rout    (rout_sel)
    );

    assign bus.Rin     = rin_sel;
    assign bus.Rout    = rout_sel;
    assign bus.PCout   = st.pc_out;
    assign bus.Zlowout = st.zlow_out;
    assign bus.MDRout  = st.mdr_out;
    assign bus.Cout    = st.c_out;
    assign bus.C_sext  = st.c_out ? {{(32-CW){bus.IR[CW-1]}}, bus.IR[CW-1:0]} : 32'd0;
    assign bus.MARin   = st.mar_in;
    assign bus.MDRin   = st.mdr_in;
    assign bus.IRin    = st.ir_in;
    assign bus.Yin     = st.y_in;
    assign bus.Zin     = st.z_in;
    assign bus.PCin    = st.pc_in;
    assign bus.IncPC   = st.inc_pc;
    assign bus.Read    = st.read;
    assign bus.Write   = st.write;
    assign bus.alu_op  = alu_sel;
    assign bus.run     = st.run;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed per-cycle vectors for the control sequencer, plus hand-built halt and abort sequences.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clock;
    logic clear;
    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [13:0] B_PCOUT  = 14'h2000;
    localparam logic [13:0] B_ZLOW   = 14'h1000;
    localparam logic [13:0] B_MDROUT = 14'h0800;
    localparam logic [13:0] B_COUT   = 14'h0400;
    localparam logic [13:0] B_MARIN  = 14'h0200;
    localparam logic [13:0] B_MDRIN  = 14'h0100;
    localparam logic [13:0] B_IRIN   = 14'h0080;
    localparam logic [13:0] B_YIN    = 14'h0040;
    localparam logic [13:0] B_ZIN    = 14'h0020;
    localparam logic [13:0] B_PCIN   = 14'h0010;
    localparam logic [13:0] B_INCPC  = 14'h0008;
    localparam logic [13:0] B_READ   = 14'h0004;
    localparam logic [13:0] B_WRITE  = 14'h0002;
    localparam logic [13:0] B_RUN    = 14'h0001;

    localparam logic [13:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [13:0] F_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [13:0] F_T2 = B_MDROUT | B_IRIN | B_RUN;

    localparam logic [31:0] I_AND  = 32'h28918000;
    localparam logic [31:0] I_LDI  = 32'h09000005;
    localparam logic [31:0] I_ST   = 32'h10800087;
    localparam logic [31:0] I_LD   = 32'h0117FFFF;
    localparam logic [31:0] I_ORI  = 32'h69800012;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_UND  = 32'hF8000000;
    localparam logic [31:0] I_ROL  = 32'h57F68000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_ADD  = 32'h1A2B0000;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        clr;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] str;
        logic [3:0]  alu;
        logic [31:0] csext;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string n, logic [31:0] ir, logic clr, logic [15:0] rin,
                                logic [15:0] rout, logic [13:0] str, logic [3:0] alu,
                                logic [31:0] cs);
        vec_t v;
        v.name = n; v.ir = ir; v.clr = clr; v.rin = rin; v.rout = rout;
        v.str = str; v.alu = alu; v.csext = cs;
        return v;
    endfunction

    function automatic void add_fetch(string tag, logic [31:0] ir);
        vecs.push_back(mk({tag, ".T0"}, ir, 1'b1, 16'h0, 16'h0, F_T0, ALU_ADD, 32'h0));
        vecs.push_back(mk({tag, ".T1"}, ir, 1'b1, 16'h0, 16'h0, F_T1, ALU_NONE, 32'h0));
        vecs.push_back(mk({tag, ".T2"}, ir, 1'b1, 16'h0, 16'h0, F_T2, ALU_NONE, 32'h0));
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(vec_t v);
        int          nsrc;
        logic [13:0] act_str;
        @(negedge clock);
        bus.IR = v.ir;
        clear  = v.clr;
        #1;
        act_str = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.MARin, bus.MDRin,
                   bus.IRin, bus.Yin, bus.Zin, bus.PCin, bus.IncPC, bus.Read, bus.Write,
                   bus.run};
        check({v.name, ".Rin"},    64'(bus.Rin),    64'(v.rin));
        check({v.name, ".Rout"},   64'(bus.Rout),   64'(v.rout));
        check({v.name, ".strobe"}, 64'(act_str),    64'(v.str));
        check({v.name, ".alu_op"}, 64'(bus.alu_op), 64'(v.alu));
        check({v.name, ".C_sext"}, 64'(bus.C_sext), 64'(v.csext));
        nsrc = int'(bus.Rout != 16'h0) + int'(bus.PCout) + int'(bus.Zlowout)
             + int'(bus.MDRout) + int'(bus.Cout);
        check({v.name, ".bus_src"}, 64'(nsrc <= 1), 64'd1);
        check({v.name, ".sel_1hot"}, 64'($onehot0(bus.Rin) && $onehot0(bus.Rout)), 64'd1);
    endtask

    initial begin
        clear  = 1'b0;
        bus.IR = 32'h0;

        vecs.push_back(mk("rst_low",  32'h0, 1'b0, 16'h0, 16'h0, 14'h0, ALU_NONE, 32'h0));
        vecs.push_back(mk("rst_idle", 32'h0, 1'b1, 16'h0, 16'h0, 14'h0, ALU_NONE, 32'h0));

        add_fetch("and", I_AND);
        vecs.push_back(mk("and.T3", I_AND, 1'b1, 16'h0,    16'h0004, B_YIN | B_RUN,  ALU_NONE, 32'h0));
        vecs.push_back(mk("and.T4", I_AND, 1'b1, 16'h0,    16'h0008, B_ZIN | B_RUN,  ALU_AND,  32'h0));
        vecs.push_back(mk("and.T5", I_AND, 1'b1, 16'h0002, 16'h0,    B_ZLOW | B_RUN, ALU_NONE, 32'h0));

        add_fetch("ldi", I_LDI);
        vecs.push_back(mk("ldi.T3", I_LDI, 1'b1, 16'h0,    16'h0, B_YIN | B_RUN,          ALU_NONE, 32'h0));
        vecs.push_back(mk("ldi.T4", I_LDI, 1'b1, 16'h0,    16'h0, B_COUT | B_ZIN | B_RUN, ALU_ADD,  32'h00000005));
        vecs.push_back(mk("ldi.T5", I_LDI, 1'b1, 16'h0004, 16'h0, B_ZLOW | B_RUN,         ALU_NONE, 32'h0));

        add_fetch("st", I_ST);
        vecs.push_back(mk("st.T3", I_ST, 1'b1, 16'h0, 16'h0,    B_YIN | B_RUN,            ALU_NONE, 32'h0));
        vecs.push_back(mk("st.T4", I_ST, 1'b1, 16'h0, 16'h0,    B_COUT | B_ZIN | B_RUN,   ALU_ADD,  32'h00000087));
        vecs.push_back(mk("st.T5", I_ST, 1'b1, 16'h0, 16'h0,    B_ZLOW | B_MARIN | B_RUN, ALU_NONE, 32'h0));
        vecs.push_back(mk("st.T6", I_ST, 1'b1, 16'h0, 16'h0002, B_MDRIN | B_RUN,          ALU_NONE, 32'h0));
        vecs.push_back(mk("st.T7", I_ST, 1'b1, 16'h0, 16'h0,    B_WRITE | B_RUN,          ALU_NONE, 32'h0));

        add_fetch("ld", I_LD);
        vecs.push_back(mk("ld.T3", I_LD, 1'b1, 16'h0,    16'h0004, B_YIN | B_RUN,            ALU_NONE, 32'h0));
        vecs.push_back(mk("ld.T4", I_LD, 1'b1, 16'h0,    16'h0,    B_COUT | B_ZIN | B_RUN,   ALU_ADD,  32'hFFFFFFFF));
        vecs.push_back(mk("ld.T5", I_LD, 1'b1, 16'h0,    16'h0,    B_ZLOW | B_MARIN | B_RUN, ALU_NONE, 32'h0));
        vecs.push_back(mk("ld.T6", I_LD, 1'b1, 16'h0,    16'h0,    B_READ | B_MDRIN | B_RUN, ALU_NONE, 32'h0));
        vecs.push_back(mk("ld.T7", I_LD, 1'b1, 16'h0004, 16'h0,    B_MDROUT | B_RUN,         ALU_NONE, 32'h0));

        add_fetch("ori", I_ORI);
        vecs.push_back(mk("ori.T3", I_ORI, 1'b1, 16'h0,    16'h0001, B_YIN | B_RUN,          ALU_NONE, 32'h0));
        vecs.push_back(mk("ori.T4", I_ORI, 1'b1, 16'h0,    16'h0,    B_COUT | B_ZIN | B_RUN, ALU_OR,   32'h00000012));
        vecs.push_back(mk("ori.T5", I_ORI, 1'b1, 16'h0008, 16'h0,    B_ZLOW | B_RUN,         ALU_NONE, 32'h0));

        add_fetch("nop", I_NOP);
        add_fetch("undef", I_UND);

        add_fetch("rol", I_ROL);
        vecs.push_back(mk("rol.T3", I_ROL, 1'b1, 16'h0,    16'h4000, B_YIN | B_RUN,  ALU_NONE, 32'h0));
        vecs.push_back(mk("rol.T4", I_ROL, 1'b1, 16'h0,    16'h2000, B_ZIN | B_RUN,  ALU_ROL,  32'h0));
        vecs.push_back(mk("rol.T5", I_ROL, 1'b1, 16'h8000, 16'h0,    B_ZLOW | B_RUN, ALU_NONE, 32'h0));

        foreach (vecs[i]) step(vecs[i]);

        // Halt: parked with everything low for 20 cycles, released only by clear.
        step(mk("halt.T0", I_HALT, 1'b1, 16'h0, 16'h0, F_T0, ALU_ADD,  32'h0));
        step(mk("halt.T1", I_HALT, 1'b1, 16'h0, 16'h0, F_T1, ALU_NONE, 32'h0));
        step(mk("halt.T2", I_HALT, 1'b1, 16'h0, 16'h0, F_T2, ALU_NONE, 32'h0));
        for (int k = 0; k < 20; k++)
            step(mk($sformatf("halt.hold%0d", k), I_HALT, 1'b1, 16'h0, 16'h0, 14'h0, ALU_NONE, 32'h0));
        step(mk("halt.clr_low", I_HALT, 1'b0, 16'h0, 16'h0, 14'h0, ALU_NONE, 32'h0));
        step(mk("halt.clr_rel", I_ADD,  1'b1, 16'h0, 16'h0, 14'h0, ALU_NONE, 32'h0));

        // Abort: clear dropped during T4 of an add kills the strobes at once.
        step(mk("add.T0", I_ADD, 1'b1, 16'h0, 16'h0,    F_T0,          ALU_ADD,  32'h0));
        step(mk("add.T1", I_ADD, 1'b1, 16'h0, 16'h0,    F_T1,          ALU_NONE, 32'h0));
        step(mk("add.T2", I_ADD, 1'b1, 16'h0, 16'h0,    F_T2,          ALU_NONE, 32'h0));
        step(mk("add.T3", I_ADD, 1'b1, 16'h0, 16'h0020, B_YIN | B_RUN, ALU_NONE, 32'h0));
        step(mk("add.T4_abort", I_ADD, 1'b0, 16'h0, 16'h0, 14'h0, ALU_NONE, 32'h0));
        step(mk("add.reset",    I_ADD, 1'b1, 16'h0, 16'h0, 14'h0, ALU_NONE, 32'h0));
        step(mk("add.refetch",  I_ADD, 1'b1, 16'h0, 16'h0, F_T0,  ALU_ADD,  32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
